// File: rtl/comparator_arbiter_pkg.sv
// rtl/comparator_arbiter_pkg.sv - shared state encodings and constants for the comparator arbiter
package comparator_arbiter_pkg;

    localparam int OPW          = 8;
    localparam int DEFAULT_NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/comparator_arbiter_if.sv
// rtl/comparator_arbiter_if.sv - requester-side bundle of the shared comparator
interface comparator_arbiter_if #(
    parameter int NREQ = comparator_arbiter_pkg::DEFAULT_NREQ
) ();
    import comparator_arbiter_pkg::*;

    logic [NREQ-1:0]     req;
    logic [OPW*NREQ-1:0] a_bus;
    logic [OPW*NREQ-1:0] b_bus;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                res_l;
    logic                res_e;
    logic                res_g;
    logic                busy;

    modport master (
        output req, a_bus, b_bus,
        input  gnt, done, res_l, res_e, res_g, busy
    );

    modport slave (
        input  req, a_bus, b_bus,
        output gnt, done, res_l, res_e, res_g, busy
    );

endinterface

// File: rtl/eight_bit_comparator.sv
// rtl/eight_bit_comparator.sv - unsigned 8-bit magnitude comparator
module eight_bit_comparator
    import comparator_arbiter_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic           l,
    output logic           e,
    output logic           g
);

    assign l = (a <  b);
    assign e = (a == b);
    assign g = (a >  b);

endmodule

// File: rtl/comparator_arbiter.sv
// rtl/comparator_arbiter.sv - round-robin sharing of one comparator among NREQ requesters
module comparator_arbiter
    import comparator_arbiter_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int IDXW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    comparator_arbiter_if.slave  bus
);

    state_t          state_q;
    state_t          state_d;
    logic [OPW-1:0]  op_a;
    logic [OPW-1:0]  op_b;
    logic [IDXW-1:0] cur_idx;
    logic [IDXW-1:0] rr_ptr;
    logic            res_l_q;
    logic            res_e_q;
    logic            res_g_q;
    logic            cmp_l;
    logic            cmp_e;
    logic            cmp_g;
    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [NREQ-1:0] cur_onehot;

    // Winner is the first requester after ptr in circular order; the requester
    // at ptr itself is checked last, which gives it the lowest priority.
    function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] reqs,
                                              input logic [IDXW-1:0] ptr);
        logic [IDXW:0]   pick;
        logic [IDXW-1:0] cand_idx;
        int              cand;
        pick = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand     = (int'(ptr) + k) % NREQ;
            cand_idx = IDXW'(cand);
            if (reqs[cand_idx]) begin
                pick = {1'b1, cand_idx};
            end
        end
        return pick;
    endfunction

    assign {win_found, win_idx} = rr_pick(bus.req, rr_ptr);
    assign cur_onehot           = NREQ'(1) << cur_idx;

    // The shared comparator only ever sees the latched operands.
    eight_bit_comparator u_cmp (
        .a (op_a),
        .b (op_b),
        .l (cmp_l),
        .e (cmp_e),
        .g (cmp_g)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant/done/busy decode; unused encodings fall back to IDLE.
    always_comb begin
        state_d  = ST_IDLE;
        bus.gnt  = '0;
        bus.done = '0;
        bus.busy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = win_found ? ST_CMP : ST_IDLE;
            end
            ST_CMP: begin
                state_d  = ST_RESP;
                bus.gnt  = cur_onehot;
                bus.busy = 1'b1;
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                bus.gnt  = cur_onehot;
                bus.done = cur_onehot;
                bus.busy = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand capture on grant, result capture at end of CMP, pointer update in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            cur_idx <= '0;
            rr_ptr  <= IDXW'(NREQ - 1);
            res_l_q <= 1'b0;
            res_e_q <= 1'b0;
            res_g_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        op_a    <= bus.a_bus[int'(win_idx)*OPW +: OPW];
                        op_b    <= bus.b_bus[int'(win_idx)*OPW +: OPW];
                        cur_idx <= win_idx;
                    end
                end
                ST_CMP: begin
                    res_l_q <= cmp_l;
                    res_e_q <= cmp_e;
                    res_g_q <= cmp_g;
                end
                ST_RESP: begin
                    rr_ptr <= cur_idx;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.res_l = res_l_q;
    assign bus.res_e = res_e_q;
    assign bus.res_g = res_g_q;

endmodule

// File: tb/tb_comparator_arbiter.sv
// tb/tb_comparator_arbiter.sv - self-checking bench for comparator_arbiter
module tb_comparator_arbiter;
    import comparator_arbiter_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    comparator_arbiter_if #(.NREQ(N)) bus ();

    comparator_arbiter #(.NREQ(N), .IDXW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Transaction-level reference: cycles left in the running transaction,
    // who owns it, who was served last, and the published result {L,E,G}.
    int         m_left;
    int         m_idx;
    int         m_last;
    logic [2:0] m_res;
    logic [2:0] m_pend;

    int         dl_cyc[$];
    int         dl_idx[$];
    logic [2:0] dl_res[$];

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] exp_res;
    } vec_t;

    vec_t vt[8];

    function automatic logic [2:0] res_of(input logic [7:0] a, input logic [7:0] b);
        if (a < b)       return 3'b100;
        else if (a == b) return 3'b010;
        else             return 3'b001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_left = 0;
            m_idx  = 0;
            m_last = N - 1;
            m_res  = 3'b000;
        end else if (m_left == 2) begin
            m_left = 1;
            m_res  = m_pend;
        end else if (m_left == 1) begin
            m_left = 0;
            m_last = m_idx;
        end else if (bus.req != '0) begin
            for (int k = N; k >= 1; k--) begin
                if (bus.req[(m_last + k) % N]) m_idx = (m_last + k) % N;
            end
            m_pend = res_of(bus.a_bus[8*m_idx +: 8], bus.b_bus[8*m_idx +: 8]);
            m_left = 2;
        end
    endtask

    task automatic model_check();
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        eg = (m_left > 0)  ? N'(1) << m_idx : '0;
        ed = (m_left == 1) ? N'(1) << m_idx : '0;
        check($sformatf("model@%0d {gnt,done,busy,lEg}", cyc),
              {20'd0, bus.gnt, bus.done, bus.busy, bus.res_l, bus.res_e, bus.res_g},
              {20'd0, eg, ed, (m_left > 0), m_res});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        model_check();
        if (bus.done != '0) begin
            for (int i = 0; i < N; i++) begin
                if (bus.done[i]) dl_idx.push_back(i);
            end
            dl_cyc.push_back(cyc);
            dl_res.push_back({bus.res_l, bus.res_e, bus.res_g});
        end
    endtask

    task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
        bus.a_bus[8*idx +: 8] = a;
        bus.b_bus[8*idx +: 8] = b;
    endtask

    function automatic logic [2:0] res_now();
        return {bus.res_l, bus.res_e, bus.res_g};
    endfunction

    initial begin
        int         t0;
        logic [2:0] exp_rr [5];
        logic [3:0] r;
        logic [7:0] ra;
        logic [7:0] rb;

        vt[0] = '{0, 8'h5A, 8'h5A, 3'b010};
        vt[1] = '{1, 8'h00, 8'hFF, 3'b100};
        vt[2] = '{2, 8'hFF, 8'h00, 3'b001};
        vt[3] = '{3, 8'hFF, 8'hFF, 3'b010};
        vt[4] = '{0, 8'h7F, 8'h80, 3'b100};
        vt[5] = '{1, 8'h80, 8'h7F, 3'b001};
        vt[6] = '{2, 8'h00, 8'h00, 3'b010};
        vt[7] = '{3, 8'hFE, 8'hFF, 3'b100};
        exp_rr = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b100};

        m_left = 0; m_idx = 0; m_last = N - 1; m_res = 3'b000; m_pend = 3'b000;

        // Reset with every request held, operands A_i = 80+i, B_i = 82.
        rst     = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < N; i++) set_ops(i, 8'h80 + 8'(i), 8'h82);
        tick();
        tick();
        check("reset gnt", 32'(bus.gnt), 0);
        check("reset done", 32'(bus.done), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset res", 32'(res_now()), 0);

        dl_cyc.delete(); dl_idx.delete(); dl_res.delete();
        rst = 1'b0;
        tick();
        t0 = cyc;
        check("first grant", 32'(bus.gnt), 32'h1);
        for (int k = 0; k < 13; k++) tick();
        check("rr done count", 32'(dl_idx.size()), 5);
        for (int k = 0; k < 5 && k < dl_idx.size(); k++) begin
            check($sformatf("rr order %0d", k), 32'(dl_idx[k]), 32'(k % N));
            check($sformatf("rr res %0d", k), 32'(dl_res[k]), 32'(exp_rr[k]));
            if (k == 0) check("rr latency", 32'(dl_cyc[0] - t0), 1);
            else        check($sformatf("rr spacing %0d", k), 32'(dl_cyc[k] - dl_cyc[k-1]), 3);
        end
        bus.req = '0;
        tick();
        tick();

        // Single-requester table vectors.
        for (int v = 0; v < 8; v++) begin
            bus.a_bus = {N{8'h33}};
            bus.b_bus = {N{8'hC3}};
            set_ops(vt[v].idx, vt[v].a, vt[v].b);
            bus.req = 4'(1 << vt[v].idx);
            tick();
            check($sformatf("vec%0d gnt", v), 32'(bus.gnt), 32'(1 << vt[v].idx));
            check($sformatf("vec%0d early done", v), 32'(bus.done), 0);
            tick();
            check($sformatf("vec%0d done", v), 32'(bus.done), 32'(1 << vt[v].idx));
            check($sformatf("vec%0d res", v), 32'(res_now()), 32'(vt[v].exp_res));
            bus.req = '0;
            tick();
            check($sformatf("vec%0d idle", v), {31'd0, bus.busy}, 0);
        end

        // Operand change during CMP must not affect the result.
        bus.req = 4'b0100;
        set_ops(2, 8'h01, 8'hFF);
        tick();
        set_ops(2, 8'hFF, 8'hFF);
        tick();
        check("sample done", 32'(bus.done), 32'h4);
        check("sample res", 32'(res_now()), 32'b100);
        bus.req = '0;
        tick();

        // Reset during CMP aborts without done.
        bus.req = 4'b0010;
        set_ops(1, 8'h44, 8'h22);
        tick();
        check("abort gnt before", 32'(bus.gnt), 32'h2);
        rst = 1'b1;
        tick();
        check("abort gnt", 32'(bus.gnt), 0);
        check("abort done", 32'(bus.done), 0);
        check("abort busy", 32'(bus.busy), 0);
        check("abort res", 32'(res_now()), 0);
        rst = 1'b0;
        set_ops(1, 8'h10, 8'h20);
        tick();
        check("post-abort gnt", 32'(bus.gnt), 32'h2);
        tick();
        check("post-abort done", 32'(bus.done), 32'h2);
        check("post-abort res", 32'(res_now()), 32'b100);
        bus.req = '0;
        tick();

        // req3 alone three times, then req0 joins and is served next.
        bus.req = 4'b1000;
        set_ops(3, 8'h00, 8'h00);
        for (int t = 0; t < 3; t++) begin
            tick();
            tick();
            check($sformatf("solo%0d done", t), 32'(bus.done), 32'h8);
            check($sformatf("solo%0d res", t), 32'(res_now()), 32'b010);
            tick();
        end
        bus.req = 4'b1001;
        set_ops(0, 8'hFF, 8'h00);
        tick();
        check("join gnt", 32'(bus.gnt), 32'h1);
        tick();
        check("join done", 32'(bus.done), 32'h1);
        check("join res", 32'(res_now()), 32'b001);
        bus.req = 4'b1000;
        tick();
        tick();
        check("return gnt", 32'(bus.gnt), 32'h8);
        bus.req = '0;
        tick();
        tick();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            r = bus.req;
            for (int i = 0; i < N; i++) begin
                if (bus.done[i])                     r[i] = ($urandom_range(0, 3) == 0);
                else if (!r[i])                      r[i] = ($urandom_range(0, 4) == 0);
                else if ($urandom_range(0, 40) == 0) r[i] = 1'b0;
            end
            bus.req = r;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ra = 8'($urandom);
                    rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
                    set_ops(i, ra, rb);
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        bus.req = '0;
        tick();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
